lsu_arb: RTL

Two-requester arbiter and transaction sequencer for the single load/store unit port. Sits between the core's memory stage (requester 0) and the debug/boot-loader port (requester 1) on one side and the LSU command inputs (address, store data, byte mask, write enable, load data) on the other. Serialises one transaction at a time and returns load data or a store acknowledge to the winning requester. Accounts for a configurable load-data latency.

---
 rtl/lsu_arb_pkg.sv | 29 ++
 rtl/lsu_arb_pick.sv | 23 ++
 rtl/lsu_arb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU arbiter: FSM states, requester id and the latched command.
package lsu_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef logic id_t;

  typedef struct packed {
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
    id_t               id;
  } cmd_t;

  // The requester that is not the given one; with two requesters this is a flip.
  function automatic id_t other_id(input id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/lsu_arb_pick.sv
// Two-way request picker: round-robin against the last winner, or fixed priority to requester 0.
module lsu_arb_pick
  import lsu_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  id_t        last,
  input  logic       mode,
  output id_t        winner,
  output logic       valid
);

  // A lone request always wins; a tie goes to the non-last requester, or to 0 in fixed mode.
  always_comb begin
    valid  = |reqs;
    winner = 1'b0;
    if (reqs == 2'b11) begin
      winner = mode ? 1'b0 : other_id(last);
    end else if (reqs[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/lsu_arb.sv
// Arbiter and one-at-a-time transaction sequencer for the shared LSU port.
module lsu_arb
  import lsu_arb_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_mask,
  output logic        o_m0_gnt,
  output logic        o_m0_done,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_mask,
  output logic        o_m1_gnt,
  output logic        o_m1_done,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_stData,
  output logic [3:0]  o_lsu_mask,
  output logic        o_lsu_wren,
  input  logic [31:0] i_lsu_ldData
);

  // The WAIT counter starts at RD_LAT-1 so the capture lands exactly RD_LAT cycles after ISSUE.
  localparam int   CNT_INIT = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam logic MODE_FP  = (ARB_MODE != 0);

  state_t      state_q;
  cmd_t        cmd_q;
  logic [1:0]  cnt_q;
  id_t         last_q;
  logic        done0_q;
  logic        done1_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  id_t         pick_winner;
  logic        pick_valid;
  logic        grant_en;
  cmd_t        win_cmd;
  logic        cap_en;
  logic [31:0] cap_data;

  lsu_arb_pick u_pick (
    .reqs   ({i_m1_req, i_m0_req}),
    .last   (last_q),
    .mode   (MODE_FP),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Grants are only handed out from IDLE and never while reset is held.
  always_comb begin
    grant_en = (state_q == IDLE) && pick_valid && !i_reset;
    o_m0_gnt = grant_en && (pick_winner == 1'b0);
    o_m1_gnt = grant_en && (pick_winner == 1'b1);
  end

  // Gather the winning requester's fields into one command for latching.
  always_comb begin
    if (pick_winner == 1'b1) begin
      win_cmd = '{wren: i_m1_wren, addr: i_m1_addr, wdata: i_m1_wdata,
                  mask: i_m1_mask, id: 1'b1};
    end else begin
      win_cmd = '{wren: i_m0_wren, addr: i_m0_addr, wdata: i_m0_wdata,
                  mask: i_m0_mask, id: 1'b0};
    end
  end

  // Decide when the transaction finishes; stores complete with zero data, loads sample the LSU.
  always_comb begin
    cap_en = 1'b0;
    if (state_q == ISSUE) begin
      cap_en = cmd_q.wren || (RD_LAT == 0);
    end else if (state_q == WAIT) begin
      cap_en = (cnt_q == 2'd0);
    end
    cap_data = cmd_q.wren ? 32'd0 : i_lsu_ldData;
  end

  // Sequencer FSM with registered completion outputs for the owning requester.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      cnt_q    <= 2'd0;
      last_q   <= 1'b1;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      done0_q  <= cap_en && (cmd_q.id == 1'b0);
      done1_q  <= cap_en && (cmd_q.id == 1'b1);
      rdata0_q <= (cap_en && (cmd_q.id == 1'b0)) ? cap_data : 32'd0;
      rdata1_q <= (cap_en && (cmd_q.id == 1'b1)) ? cap_data : 32'd0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            cmd_q   <= win_cmd;
            last_q  <= pick_winner;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (cap_en) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= 2'(CNT_INIT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cap_en) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // LSU command drive: address and store data hold, mask/enable only live during a transaction.
  always_comb begin
    o_lsu_addr   = cmd_q.addr;
    o_lsu_stData = cmd_q.wdata;
    o_lsu_mask   = ((state_q == ISSUE) || (state_q == WAIT)) ? cmd_q.mask : 4'd0;
    o_lsu_wren   = (state_q == ISSUE) && cmd_q.wren;
    o_m0_done    = done0_q;
    o_m1_done    = done1_q;
    o_m0_rdata   = rdata0_q;
    o_m1_rdata   = rdata1_q;
  end

endmodule
